// File: rtl/mux_8to1_rr.sv
// 8-to-1 round-robin stream multiplexer with a single registered output stage.
// Each output beat carries the index of the channel it came from on out_sel.
module mux_8to1_rr #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_valid,
    input  logic [8*DATA_W-1:0]   in_data,
    output logic [7:0]            in_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [2:0]            out_sel,
    input  logic                  out_ready
);

    logic [2:0]        ptr_reg;
    logic [2:0]        grant;
    logic [2:0]        idx;
    logic              found;
    logic              load;
    logic              req_any;
    logic              take;
    logic [DATA_W-1:0] chan_data [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_split
        assign chan_data[gi] = in_data[gi*DATA_W +: DATA_W];
    end

    // Scan from the priority pointer upward, wrapping; first requester wins.
    always_comb begin
        grant = ptr_reg;
        found = 1'b0;
        idx   = ptr_reg;
        for (int i = 0; i < 8; i++) begin
            idx = ptr_reg + 3'(i);
            if (!found && in_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign load     = !out_valid || out_ready;
    assign req_any  = |in_valid;
    // rst gating keeps every channel stalled while the block is held in reset.
    assign take     = load && req_any && !rst;
    assign in_ready = take ? (8'b1 << grant) : 8'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 3'd0;
            ptr_reg   <= 3'd0;
        end else if (load && req_any) begin
            out_valid <= 1'b1;
            out_data  <= chan_data[grant];
            out_sel   <= grant;
            ptr_reg   <= grant + 3'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_8to1_rr.sv
// Directed self-checking bench for mux_8to1_rr: reset, rotation, wrap/skip,
// backpressure, drain without refill and asynchronous reset during a stall.
module tb_mux_8to1_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_valid = 8'h00;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    mux_8to1_rr #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [2:0] s);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        check({tag, ".out_data"},  32'(out_data),  32'(d));
        check({tag, ".out_sel"},   32'(out_sel),   32'(s));
        $display("step %s: valid=%0d data=%0h sel=%0d", tag, out_valid, out_data, out_sel);
    endtask

    task automatic set_data(input int k, input logic [7:0] v);
        in_data[k*8 +: 8] = v;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) set_data(k, 8'(8'h10 + k));
        in_valid  = 8'hFF;
        out_ready = 1'b1;

        // Reset held with all channels requesting
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 8'h00, 3'd0);
        check("reset.in_ready", 32'(in_ready), 32'h00);

        // Release; full rotation for 16 beats starting at channel 0
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            check($sformatf("rot%0d.in_ready", c), 32'(in_ready), 32'(8'h01 << (c % 8)));
            @(posedge clk);
            #1;
            check_out($sformatf("rot%0d", c), 1'b1, 8'(8'h10 + (c % 8)), 3'(c % 8));
        end

        // Single channel 5
        @(negedge clk);
        in_valid = 8'b0010_0000;
        set_data(5, 8'hA5);
        #1;
        check("single.in_ready", 32'(in_ready), 32'h20);
        @(posedge clk);
        #1;
        check_out("single", 1'b1, 8'hA5, 3'd5);

        // ptr is now 6; channels 0 and 2 alternate, 6/7 skipped
        @(negedge clk);
        in_valid = 8'b0000_0101;
        for (int c = 0; c < 4; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            check($sformatf("wrap%0d.in_ready", c), 32'(in_ready), (c % 2 == 0) ? 32'h01 : 32'h04);
            @(posedge clk);
            #1;
            check_out($sformatf("wrap%0d", c), 1'b1, (c % 2 == 0) ? 8'h10 : 8'h12,
                      (c % 2 == 0) ? 3'd0 : 3'd2);
        end

        // Load a beat from channel 3 (ptr is 3)
        @(negedge clk);
        in_valid = 8'b0000_1000;
        set_data(3, 8'h3C);
        @(posedge clk);
        #1;
        check_out("bp.load", 1'b1, 8'h3C, 3'd3);

        // Stall 5 cycles with every channel requesting
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            check($sformatf("stall%0d.in_ready", c), 32'(in_ready), 32'h00);
            @(posedge clk);
            #1;
            check_out($sformatf("stall%0d", c), 1'b1, 8'h3C, 3'd3);
        end

        // Release: drain and load channel 4 on the same edge
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("release.in_ready", 32'(in_ready), 32'h10);
        @(posedge clk);
        #1;
        check_out("release", 1'b1, 8'h14, 3'd4);

        // Drain with no requests: valid drops, data/sel hold
        @(negedge clk);
        in_valid = 8'h00;
        #1;
        check("drain.in_ready", 32'(in_ready), 32'h00);
        @(posedge clk);
        #1;
        check_out("drain", 1'b0, 8'h14, 3'd4);

        // Hold a beat from channel 6, then async reset mid-stall
        @(negedge clk);
        in_valid = 8'b0100_0000;
        @(posedge clk);
        #1;
        check_out("hold6", 1'b1, 8'h16, 3'd6);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 8'hFF;
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 8'h00, 3'd0);
        check("async_rst.in_ready", 32'(in_ready), 32'h00);
        #1;
        rst = 1'b0;
        #0.5;
        check("post_rst.in_ready", 32'(in_ready), 32'h01);
        @(posedge clk);
        #1;
        check_out("post_rst", 1'b1, 8'h10, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        n_fail++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_8to1_rr.md
Name: mux_8to1_rr

Overview:
- 8-input to 1-output round-robin multiplexer with a registered output stage and a valid/ready handshake on every port.
- Gathers the eight channel streams onto one stream and tags each beat with a 3-bit channel index, `out_sel`.
- `out_sel` uses the same encoding a downstream 1-to-8 demux consumes as its select (bit 0 = s0, bit 1 = s1, bit 2 = s2). Index k selects output yk.
- Sits at the collecting end of a link whose far side redistributes beats by that select.

Parameters:
- DATA_W, 8, width of each channel's data word.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  8  bit k = channel k presents a beat.
- in_data  input  8*DATA_W  channel k data at bits [k*DATA_W +: DATA_W].
- in_ready  output  8  bit k = channel k's beat is accepted this cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  DATA_W  data of the held beat.
- out_sel  output  3  source channel index of the held beat (0..7).
- out_ready  input  1  downstream accepts the held beat this cycle.

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0.
  - in_ready=0 while rst is high.
- Handshakes:
  - Input transfer on channel k occurs when in_valid[k] && in_ready[k] at a clock edge.
  - Output transfer occurs when out_valid && out_ready at a clock edge.
- Load enable: load = !out_valid || out_ready. The output register can take a new beat when it is empty or being drained in the same cycle.
- Arbitration (combinational):
  - Search channels in order ptr, ptr+1, …, ptr+7, modulo 8.
  - grant = first index with in_valid set.
  - req_any = |in_valid.
- in_ready = one-hot(grant) when load && req_any, else 0.
  - At most one bit is ever high.
  - in_ready must not depend combinationally on in_data.
- On a clock edge with load && req_any:
  - out_data <= in_data[grant]
  - out_sel <= grant
  - out_valid <= 1
  - ptr <= (grant+1) mod 8, wrapping from 7 to 0.
- On a clock edge with out_valid && out_ready && !req_any: out_valid <= 0. out_data and out_sel hold their last values.
- Stall: while out_valid && !out_ready:
  - out_valid, out_data and out_sel stay stable.
  - in_ready = 0.
  - ptr is unchanged.
- Latency: a beat accepted at edge N appears on out_* after edge N; minimum 1 cycle input-to-output.
- Throughput: 1 beat/cycle sustained when out_ready is held high. No bubble is inserted on back-to-back drain+load.
- Fairness:
  - A channel that holds in_valid high is granted within 8 accepted beats.
  - With all 8 channels requesting, grants are issued in strict rotation: ptr, ptr+1, …
- Upstream rules (not checked by the block):
  - A channel holds in_valid and in_data stable until accepted.
  - The block tolerates in_valid being dropped without acceptance; that channel is simply skipped.
- Simultaneous events:
  - Drain and load on the same edge: the new beat replaces the old one; out_valid stays 1.
  - Pointer advances only on an accepted input beat.
- Reset mid-operation: a held beat is discarded; out_valid goes 0 immediately, asynchronously; ptr returns to 0.
- No data storage beyond the single output register; no beat is ever duplicated or dropped.

Test Plan:
- Reset: assert rst with in_valid=8'hFF, out_ready=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0. Release rst -> first accepted beat comes from channel 0, with out_sel=0.
- Single channel: in_valid=8'b0010_0000, channel 5 data=8'hA5, out_ready=1 -> in_ready=8'b0010_0000. Next cycle out_valid=1, out_data=8'hA5, out_sel=3'd5, ptr=6.
- Full rotation: all channels valid, channel k data=8'h10+k, out_ready=1 for 16 cycles -> out_sel sequence 0,1,…,7,0,…,7. out_data tracks it; out_valid stays high every cycle after the first.
- Wrap and skip: ptr=6 with in_valid=8'b0000_0101 -> grant order 0, 2, 0, 2, …. Channel 7 and channel 6 are never selected.
- Backpressure: out_ready=0 for 5 cycles with beat (sel=3, data=8'h3C) held -> out_* constant and in_ready=0 throughout. On out_ready=1 the next grant loads on the same edge.
- Async reset during stall: held beat valid, pulse rst between clock edges -> out_valid drops before the next edge. After release, arbitration restarts at channel 0.
